// File: rtl/tile_binarize_sequencer.sv
// Tile-mean binarizer: buffers one tile of pixels, then emits one bit per pixel (pixel > tile mean).
// Optional build macro TILE_MEAN_OUT_EN adds the out_mean port carrying the current tile mean.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// LOAD  | accepting TILE_PIXELS pixels into the buffer and summing them
// MEAN  | one cycle: latch mean, prime the first output bit
// EMIT  | replaying buffered pixels as thresholded bits
module tile_binarize_sequencer #(
    parameter int TILE_LOG2       = 4,
    parameter int TILES_PER_FRAME = 36
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] in_pixel,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_bit,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic [7:0] tile_idx,
    output logic       busy,
`ifdef TILE_MEAN_OUT_EN
    output logic [7:0] out_mean,
`endif
    output logic       frame_done
);

    localparam int                   TILE_PIXELS = 2 ** TILE_LOG2;
    localparam logic [TILE_LOG2-1:0] PTR_LAST    = {TILE_LOG2{1'b1}};
    localparam logic [7:0]           TILE_LAST   = 8'(TILES_PER_FRAME - 1);

    typedef enum logic [1:0] {IDLE, LOAD, MEAN, EMIT} state_t;

    state_t               state;
    logic [7:0]           pix_buf [TILE_PIXELS];
    logic [TILE_LOG2-1:0] wr_ptr;
    logic [TILE_LOG2-1:0] rd_ptr;
    logic [TILE_LOG2-1:0] rd_next;
    logic [7+TILE_LOG2:0] sum;
    logic [7:0]           mean;
    logic [7:0]           mean_calc;
    logic                 in_xfer;
    logic                 out_xfer;

    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign mean_calc = sum[TILE_LOG2 +: 8];
    assign rd_next   = rd_ptr + TILE_LOG2'(1);

`ifdef TILE_MEAN_OUT_EN
    assign out_mean = mean;
`endif

    // Pixel storage needs no reset; it is always fully rewritten before being read.
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            pix_buf[wr_ptr] <= in_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            out_bit    <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            tile_idx   <= '0;
            sum        <= '0;
            mean       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    // The done cycle itself does not count as an idle cycle for start.
                    if (start && !frame_done) begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        tile_idx <= '0;
                        sum      <= '0;
                        wr_ptr   <= '0;
                    end
                end
                LOAD: begin
                    if (in_xfer) begin
                        sum    <= sum + (8 + TILE_LOG2)'(in_pixel);
                        wr_ptr <= wr_ptr + TILE_LOG2'(1);
                        if (wr_ptr == PTR_LAST) begin
                            state    <= MEAN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                MEAN: begin
                    mean      <= mean_calc;
                    rd_ptr    <= '0;
                    out_valid <= 1'b1;
                    out_bit   <= pix_buf[0] > mean_calc;
                    out_last  <= 1'b0;
                    state     <= EMIT;
                end
                EMIT: begin
                    if (out_xfer) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_bit   <= 1'b0;
                            out_last  <= 1'b0;
                            if (tile_idx == TILE_LAST) begin
                                frame_done <= 1'b1;
                                busy       <= 1'b0;
                                tile_idx   <= '0;
                                state      <= IDLE;
                            end else begin
                                tile_idx <= tile_idx + 8'd1;
                                sum      <= '0;
                                wr_ptr   <= '0;
                                in_ready <= 1'b1;
                                state    <= LOAD;
                            end
                        end else begin
                            rd_ptr   <= rd_next;
                            out_bit  <= pix_buf[rd_next] > mean;
                            out_last <= (rd_next == PTR_LAST);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_binarize_sequencer.sv
// Randomized bench for tile_binarize_sequencer against a queue-based tile-mean model.
`timescale 1ns/1ps
module tb_tile_binarize_sequencer;

    localparam int TPF  = 2;
    localparam int NPIX = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] in_pixel;
    logic       in_valid;
    logic       in_ready;
    logic       out_bit;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [7:0] tile_idx;
    logic       busy;
    logic       frame_done;
`ifdef TILE_MEAN_OUT_EN
    logic [7:0] out_mean;
`endif

    always #5 clk = ~clk;

    tile_binarize_sequencer #(.TILE_LOG2(4), .TILES_PER_FRAME(TPF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_pixel   (in_pixel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_bit    (out_bit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .tile_idx   (tile_idx),
        .busy       (busy),
`ifdef TILE_MEAN_OUT_EN
        .out_mean   (out_mean),
`endif
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic       b;
        logic       last;
        logic [7:0] tile;
        logic [7:0] mean;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  src_q[$];
    int          in_gap_pct = 0;
    int          out_stall_pct = 0;
    bit          in_xfer_seen = 0;

    exp_t        exp_q[$];
    int          pix_acc[$];
    int          load_tile = 0;
    bit          exp_busy = 0;
    bit          exp_done = 0;
    int          lat_cnt = 0;
    int          bits_cnt = 0;
    logic [15:0] cur_bits = '0;
    logic [15:0] tile_bits[$];
    int          tile_means[$];
    int          done_pulses = 0;
    bit          prev_stall = 0;
    logic        prev_bit = 1'b0;
    logic        prev_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Model: every accepted tile turns into NPIX expected bits against its integer mean.
    initial begin : monitor
        forever begin
            int   s;
            int   m;
            exp_t e;
            bit   nb;
            bit   nd;
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                pix_acc.delete();
                load_tile    = 0;
                exp_busy     = 0;
                exp_done     = 0;
                lat_cnt      = 0;
                bits_cnt     = 0;
                cur_bits     = '0;
                prev_stall   = 0;
                in_xfer_seen = 0;
            end else begin
                nb = exp_busy;
                nd = 0;
                chk("frame_done", frame_done, exp_done);
                chk("busy", busy, exp_busy);
                if (frame_done) done_pulses++;
                chk("in_ready_excl", in_ready && (out_valid || !busy), 0);
                chk("out_valid_unexpected", out_valid && (exp_q.size() == 0), 0);
                if (lat_cnt > 0) begin
                    lat_cnt--;
                    if (lat_cnt == 1) chk("latency_early", out_valid, 0);
                    else              chk("latency_first", out_valid, 1);
                end
                if (prev_stall) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_bit", out_bit, prev_bit);
                    chk("stall_last", out_last, prev_last);
                end
                in_xfer_seen = in_valid && in_ready;
                if (in_xfer_seen) begin
                    chk("tile_idx_load", tile_idx, load_tile);
                    pix_acc.push_back(int'(in_pixel));
                    if (pix_acc.size() == NPIX) begin
                        s = 0;
                        foreach (pix_acc[i]) s += pix_acc[i];
                        m = s / NPIX;
                        for (int i = 0; i < NPIX; i++) begin
                            e.b    = pix_acc[i] > m;
                            e.last = (i == NPIX - 1);
                            e.tile = 8'(load_tile);
                            e.mean = 8'(m);
                            exp_q.push_back(e);
                        end
                        load_tile = (load_tile + 1) % TPF;
                        pix_acc.delete();
                        lat_cnt = 2;
                    end
                end
                if (out_valid && out_ready && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("out_bit", out_bit, e.b);
                    chk("out_last", out_last, e.last);
                    chk("tile_idx_emit", tile_idx, e.tile);
`ifdef TILE_MEAN_OUT_EN
                    chk("out_mean", out_mean, e.mean);
`endif
                    cur_bits[bits_cnt] = out_bit;
                    bits_cnt++;
                    if (e.last) begin
                        tile_bits.push_back(cur_bits);
                        tile_means.push_back(int'(e.mean));
                        bits_cnt = 0;
                        cur_bits = '0;
                        if (int'(e.tile) == TPF - 1) begin
                            nd = 1;
                            nb = 0;
                        end
                    end
                end
                if (!exp_busy && !exp_done && start) nb = 1;
                prev_stall = out_valid && !out_ready;
                prev_bit   = out_bit;
                prev_last  = out_last;
                exp_busy   = nb;
                exp_done   = nd;
            end
        end
    end

    initial begin : driver
        in_valid  = 1'b0;
        in_pixel  = '0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                in_valid = 1'b0;
            end else begin
                if (in_xfer_seen) begin
                    in_valid = 1'b0;
                    void'(src_q.pop_front());
                end
                if (!in_valid && src_q.size() > 0 && $urandom_range(99) >= in_gap_pct) begin
                    in_valid = 1'b1;
                    in_pixel = src_q[0];
                end
                out_ready = ($urandom_range(99) >= out_stall_pct);
            end
        end
    end

    task automatic wait_tiles(input int n, input int budget);
        int k = 0;
        while (tile_bits.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk("tiles_timeout", tile_bits.size() >= n, 1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((busy || frame_done) && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("idle_timeout", busy || frame_done, 0);
    endtask

    task automatic start_frame();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic push_random(input int n);
        for (int i = 0; i < n; i++) src_q.push_back(8'($urandom_range(255)));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_bit"}, out_bit, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_tile_idx"}, tile_idx, 0);
`ifdef TILE_MEAN_OUT_EN
        chk({tag, "_out_mean"}, out_mean, 0);
`endif
    endtask

    initial begin : test
        int k;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Frame A: uniform tile then ramp tile, no stalls.
        start_frame();
        for (int i = 0; i < NPIX; i++) src_q.push_back(8'd100);
        for (int i = 0; i < NPIX; i++) src_q.push_back(8'(i * 16));
        wait_tiles(2, 400);
        chk("uniform_bits", tile_bits[0], 16'h0000);
        chk("uniform_mean", tile_means[0], 100);
        chk("ramp_bits", tile_bits[1], 16'hFF00);
        chk("ramp_mean", tile_means[1], 120);
        wait_idle(50);
        chk("done_pulses_a", done_pulses, 1);

        // Frame B: spike and saturated tile, stray start mid-frame, start on the done cycle.
        start_frame();
        for (int i = 0; i < NPIX; i++) src_q.push_back((i == 5) ? 8'd255 : 8'd0);
        for (int i = 0; i < NPIX; i++) src_q.push_back(8'd255);
        repeat (20) @(posedge clk);
        start_frame();
        k = 0;
        while (!frame_done && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("done_b_timeout", frame_done, 1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("start_on_done_ignored", busy, 0);
        chk("spike_bits", tile_bits[2], 16'h0020);
        chk("spike_mean", tile_means[2], 15);
        chk("sat_bits", tile_bits[3], 16'h0000);
        chk("sat_mean", tile_means[3], 255);
        chk("done_pulses_b", done_pulses, 2);

        // Random frames under handshake stress.
        in_gap_pct    = 30;
        out_stall_pct = 40;
        for (int f = 0; f < 4; f++) begin
            wait_idle(50);
            start_frame();
            push_random(2 * NPIX);
            wait_tiles(tile_bits.size() + 2, 3000);
        end
        wait_idle(50);
        chk("done_pulses_rand", done_pulses, 6);

        // Reset after the 7th bit of a tile has been accepted.
        in_gap_pct    = 0;
        out_stall_pct = 0;
        start_frame();
        push_random(NPIX);
        k = 0;
        while (bits_cnt != 7 && k < 400) begin
            @(posedge clk);
            k++;
        end
        chk("reset_wait_timeout", bits_cnt, 7);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        k = tile_bits.size();
        start_frame();
        for (int i = 0; i < NPIX; i++) src_q.push_back(8'd0);
        push_random(NPIX);
        wait_tiles(k + 2, 600);
        chk("after_reset_zero_bits", tile_bits[k], 16'h0000);
        wait_idle(50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tile_binarize_sequencer.md
Name: tile_binarize_sequencer

Overview:
- Sequences tile-energy binarization of a frame, one tile at a time.
- Per tile: buffers TILE_PIXELS grayscale pixels and accumulates their sum. It then derives the tile mean and replays the buffered pixels as a 1-bit stream, where a pixel outputs 1 when it is strictly greater than the mean.
- Position in the pipeline: between the tile-ordered pixel source and downstream bit-packing/grid logic. It owns tile counting and frame completion.

Parameters:
- TILE_LOG2, 4, log2 of pixels per tile. TILE_PIXELS = 2**TILE_LOG2; default 16 (4x4).
- TILES_PER_FRAME, 36, tiles per frame, range 1..256.

Ports:
- clk  input  1  system clock (27 MHz)
- rst_n  input  1  asynchronous active-low reset
- start  input  1  frame start pulse; honoured only in IDLE
- in_pixel  input  8  grayscale pixel, tile-major order
- in_valid  input  1  in_pixel valid
- in_ready  output  1  sequencer accepts pixel this cycle
- out_bit  output  1  binarized pixel
- out_valid  output  1  out_bit valid
- out_ready  input  1  downstream accepts out_bit
- out_last  output  1  marks last bit of current tile
- tile_idx  output  8  index of tile being loaded/emitted
- busy  output  1  high in any state except IDLE
- frame_done  output  1  one-cycle pulse after last bit of last tile is accepted

Behaviour:
- Reset (asynchronous, any state, including mid-tile):
  - state=IDLE.
  - in_ready, out_bit, out_valid, out_last, busy, frame_done = 0.
  - tile_idx=0, sum=0, mean=0.
  - Buffer contents don't-care.
- Storage: TILE_PIXELS x 8 register buffer. Sum register is 8+TILE_LOG2 bits (12 by default); the sum cannot overflow.
- A transfer occurs on valid&&ready. Data is held stable while valid && !ready.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 -> LOAD with tile_idx=0, sum=0, wr_ptr=0.
- LOAD:
  - in_ready=1.
  - Each accepted pixel: buf[wr_ptr]=in_pixel, sum+=in_pixel, wr_ptr++.
  - Accepting pixel TILE_PIXELS-1 -> MEAN.
  - in_valid low: stall indefinitely, no timeout.
- MEAN (1 cycle):
  - in_ready=0.
  - mean = sum >> TILE_LOG2 (truncating).
  - rd_ptr=0.
  - -> EMIT.
- EMIT:
  - out_valid=1, out_bit=(buf[rd_ptr] > mean) as an unsigned strict compare, out_last=(rd_ptr==TILE_PIXELS-1).
  - out_bit and out_last are registered: they change only on acceptance or state entry.
  - Each accept: rd_ptr++.
  - Accept with out_last:
    - If tile_idx==TILES_PER_FRAME-1: frame_done=1 for exactly the next cycle, tile_idx->0, -> IDLE.
    - Otherwise: tile_idx++, sum=0, wr_ptr=0, -> LOAD.
- Latency: last input pixel accepted at cycle T -> first out_valid at T+2.
- Throughput per tile: TILE_PIXELS input cycles + 1 + TILE_PIXELS output cycles, with no stalls. There is no input/output overlap; in_ready=0 throughout MEAN/EMIT.
- start outside IDLE is ignored and has no side effect.
- start in the same cycle frame_done is asserted is ignored, because the state is already IDLE only from that cycle and start is sampled in IDLE. A start in the cycle after frame_done is honoured.
- tile_idx holds its value through LOAD, MEAN and EMIT of a tile.
- Boundary values:
  - All pixels 255 -> mean 255 -> all bits 0.
  - All pixels 0 -> all bits 0.

Optional Feature:
- Macro: TILE_MEAN_OUT_EN.
- Defined: adds output port out_mean[7:0] carrying the current tile mean. It is valid whenever out_valid=1, updates in MEAN, and resets to 0.
- Undefined: port absent and no extra registers. Functional behaviour of all other ports is identical.

Test Plan:
- Uniform tile: start, 16 pixels all 100 -> mean 100, 16 bits all 0, out_last on bit 15, first out_valid 2 cycles after 16th input accept.
- Ramp tile: pixels 0,16,...,240 (sum 1920, mean 120) -> bits 0-7 = 0, bits 8-15 = 1; TILE_MEAN_OUT_EN build shows out_mean=120.
- Single spike: pixel 5 = 255, rest 0 (sum 255, mean 15) -> only bit 5 = 1.
- Handshake stress: random in_valid gaps and out_ready toggling -> no dropped or duplicated bits, out_bit/out_last stable while stalled, in_ready=0 during EMIT.
- Frame sequencing with TILES_PER_FRAME=2:
  - tile_idx 0 then 1.
  - frame_done single pulse after 32nd bit accepted, busy falls the same cycle.
  - start pulsed mid-frame is ignored.
  - A new start after done begins again at tile_idx 0.
- Reset mid-EMIT (after 7 bits): all outputs 0, state IDLE, tile_idx 0. The next start plus 16 pixels produces a correct full tile.
